ca90_im_search: RTL and testbench



---
 rtl/ca90_search_pkg.sv | 15 +
 rtl/ca90_hier_base.sv | 34 +++
 rtl/ca90_unit.sv | 17 +
 rtl/hv_hamming_dist.sv | 38 +++
 rtl/ca90_im_search.sv | 144 ++++++++++++++
 tb/tb_ca90_im_search.sv | 266 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/ca90_search_pkg.sv
// Shared types and helpers for the CA90 item-memory reverse lookup.
package ca90_search_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Enough bits to hold any distance from 0 to dim inclusive.
    function automatic int dist_width(input int dim);
        return $clog2(dim + 1);
    endfunction

endpackage

// File: rtl/ca90_hier_base.sv
// Expands a seed to a full-width base HV by repeated doubling: the upper half of each
// level is one CA90 step (shift 1) of the lower half.
module ca90_hier_base #(
    parameter int HVDimension = 512,
    parameter int SeedWidth   = 32
) (
    input  logic [SeedWidth-1:0]   seed_i,
    output logic [HVDimension-1:0] hv_o
);

    localparam int NumLvl   = $clog2(HVDimension / SeedWidth);
    localparam int HierPerm = 1;

    for (genvar k = 0; k <= NumLvl; k++) begin : gen_lvl
        localparam int W = SeedWidth << k;
        logic [W-1:0] lvl_hv;
        if (k == 0) begin : g_root
            assign lvl_hv = seed_i;
        end else begin : g_grow
            logic [W/2-1:0] nxt;
            ca90_unit #(
                .Dimension(W / 2),
                .Perm     (HierPerm)
            ) u_ca90 (
                .vector_i(gen_lvl[k-1].lvl_hv),
                .vector_o(nxt)
            );
            assign lvl_hv = {nxt, gen_lvl[k-1].lvl_hv};
        end
    end

    assign hv_o = gen_lvl[NumLvl].lvl_hv;

endmodule

// File: rtl/ca90_unit.sv
// One CA90 step on a cyclic vector: each bit becomes the XOR of its neighbours Perm positions away.
module ca90_unit #(
    parameter int Dimension = 512,
    parameter int Perm      = 7
) (
    input  logic [Dimension-1:0] vector_i,
    output logic [Dimension-1:0] vector_o
);

    logic [Dimension-1:0] rot_l;
    logic [Dimension-1:0] rot_r;

    assign rot_l    = {vector_i[Dimension-Perm-1:0], vector_i[Dimension-1:Dimension-Perm]};
    assign rot_r    = {vector_i[Perm-1:0], vector_i[Dimension-1:Perm]};
    assign vector_o = rot_l ^ rot_r;

endmodule

// File: rtl/hv_hamming_dist.sv
// Combinational Hamming distance: XOR, per-byte popcounts, then a sum over the bytes.
module hv_hamming_dist #(
    parameter int HVDimension = 512,
    parameter int DistWidth   = 10
) (
    input  logic [HVDimension-1:0] a_i,
    input  logic [HVDimension-1:0] b_i,
    output logic [DistWidth-1:0]   dist_o
);

    localparam int ChunkW    = 8;
    localparam int NumChunks = HVDimension / ChunkW;

    logic [HVDimension-1:0]      diff;
    logic [NumChunks-1:0][3:0]   chunk_cnt;

    assign diff = a_i ^ b_i;

    // First level kept narrow so a register stage can slot in here later.
    for (genvar c = 0; c < NumChunks; c++) begin : gen_chunk
        logic [3:0] cnt;
        always_comb begin
            cnt = '0;
            for (int b = 0; b < ChunkW; b++) begin
                cnt = cnt + {3'b000, diff[c*ChunkW+b]};
            end
        end
        assign chunk_cnt[c] = cnt;
    end

    always_comb begin
        dist_o = '0;
        for (int c = 0; c < NumChunks; c++) begin
            dist_o = dist_o + DistWidth'(chunk_cnt[c]);
        end
    end

endmodule

// File: rtl/ca90_im_search.sv
// Reverse item-memory lookup: regenerates all items one per cycle and keeps the
// lowest-index item at minimum Hamming distance from the query.
module ca90_im_search
    import ca90_search_pkg::*;
#(
    parameter int HVDimension  = 512,
    parameter int NumTotIm     = 1024,
    parameter int NumPerImBank = 128,
    parameter int Ca90ImPerm   = 7,
    parameter int SeedWidth    = 32,
    parameter int NumImSets    = NumTotIm / NumPerImBank,
    parameter int ImSelWidth   = $clog2(NumTotIm),
    parameter int DistWidth    = dist_width(HVDimension)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumImSets-1:0][SeedWidth-1:0] seed_hv_i,
    input  logic [HVDimension-1:0]              query_hv_i,
    input  logic                                query_valid_i,
    output logic                                query_ready_o,
    output logic [ImSelWidth-1:0]               result_idx_o,
    output logic [DistWidth-1:0]                result_dist_o,
    output logic                                result_valid_o,
    input  logic                                result_ready_i,
    output logic                                busy_o
);

    localparam int SetW  = $clog2(NumImSets);
    localparam int ItemW = $clog2(NumPerImBank);

    state_e                 state_q, state_d;
    logic [HVDimension-1:0] query_q, query_d;
    logic [HVDimension-1:0] cur_hv_q, cur_hv_d;
    logic [SetW-1:0]        set_cnt_q, set_cnt_d;
    logic [ItemW-1:0]       item_cnt_q, item_cnt_d;
    logic [DistWidth-1:0]   best_dist_q, best_dist_d;
    logic [ImSelWidth-1:0]  best_idx_q, best_idx_d;

    logic [SeedWidth-1:0]   seed_sel;
    logic [HVDimension-1:0] base_hv;
    logic [HVDimension-1:0] step_hv;
    logic [HVDimension-1:0] candidate;
    logic [DistWidth-1:0]   cand_dist;
    logic [ImSelWidth-1:0]  cand_idx;

    assign seed_sel  = seed_hv_i[set_cnt_q];
    assign candidate = (item_cnt_q == '0) ? base_hv : step_hv;
    assign cand_idx  = {set_cnt_q, item_cnt_q};

    ca90_hier_base #(
        .HVDimension(HVDimension),
        .SeedWidth  (SeedWidth)
    ) u_base (
        .seed_i(seed_sel),
        .hv_o  (base_hv)
    );

    ca90_unit #(
        .Dimension(HVDimension),
        .Perm     (Ca90ImPerm)
    ) u_step (
        .vector_i(cur_hv_q),
        .vector_o(step_hv)
    );

    hv_hamming_dist #(
        .HVDimension(HVDimension),
        .DistWidth  (DistWidth)
    ) u_dist (
        .a_i   (candidate),
        .b_i   (query_q),
        .dist_o(cand_dist)
    );

    always_comb begin
        state_d     = state_q;
        query_d     = query_q;
        cur_hv_d    = cur_hv_q;
        set_cnt_d   = set_cnt_q;
        item_cnt_d  = item_cnt_q;
        best_dist_d = best_dist_q;
        best_idx_d  = best_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (query_valid_i) begin
                    query_d     = query_hv_i;
                    set_cnt_d   = '0;
                    item_cnt_d  = '0;
                    best_dist_d = '1;
                    best_idx_d  = '0;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                cur_hv_d   = candidate;
                item_cnt_d = item_cnt_q + 1'b1;
                // Strict compare keeps the earliest (lowest) index on ties.
                if (cand_dist < best_dist_q) begin
                    best_dist_d = cand_dist;
                    best_idx_d  = cand_idx;
                end
                if (&item_cnt_q) begin
                    set_cnt_d = set_cnt_q + 1'b1;
                    if (&set_cnt_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (result_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            query_q     <= '0;
            cur_hv_q    <= '0;
            set_cnt_q   <= '0;
            item_cnt_q  <= '0;
            best_dist_q <= '0;
            best_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            query_q     <= query_d;
            cur_hv_q    <= cur_hv_d;
            set_cnt_q   <= set_cnt_d;
            item_cnt_q  <= item_cnt_d;
            best_dist_q <= best_dist_d;
            best_idx_q  <= best_idx_d;
        end
    end

    assign query_ready_o  = (state_q == ST_IDLE);
    assign result_valid_o = (state_q == ST_DONE);
    assign busy_o         = (state_q != ST_IDLE);
    assign result_idx_o   = best_idx_q;
    assign result_dist_o  = best_dist_q;

endmodule

// File: tb/tb_ca90_im_search.sv
// Directed bench for ca90_im_search with a golden item table and a cycle-level scoreboard.
module tb_ca90_im_search;
    localparam int D  = 512;
    localparam int N  = 1024;
    localparam int NB = 128;
    localparam int P  = 7;
    localparam int SW = 32;
    localparam int NS = N / NB;
    localparam int IW = 10;
    localparam int DW = 10;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NS-1:0][SW-1:0]   seed;
    logic [D-1:0]            query_hv;
    logic                    query_valid;
    logic                    query_ready;
    logic [IW-1:0]           result_idx;
    logic [DW-1:0]           result_dist;
    logic                    result_valid;
    logic                    result_ready;
    logic                    busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [D-1:0] items [N];

    ca90_im_search dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .seed_hv_i     (seed),
        .query_hv_i    (query_hv),
        .query_valid_i (query_valid),
        .query_ready_o (query_ready),
        .result_idx_o  (result_idx),
        .result_dist_o (result_dist),
        .result_valid_o(result_valid),
        .result_ready_i(result_ready),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Rule 90 on the low w bits of v, treated as a ring.
    function automatic logic [D-1:0] ca90_ring(input logic [D-1:0] v, input int w, input int p);
        logic [D-1:0] o;
        o = '0;
        for (int i = 0; i < w; i++) o[i] = v[(i + p) % w] ^ v[(i + w - p) % w];
        return o;
    endfunction

    function automatic logic [D-1:0] base_of(input logic [SW-1:0] s);
        logic [D-1:0] v;
        v = '0;
        v[SW-1:0] = s;
        for (int w = SW; w < D; w = w * 2) v = v | (ca90_ring(v, w, 1) << w);
        return v;
    endfunction

    task automatic build_items();
        logic [D-1:0] cur;
        for (int s = 0; s < NS; s++) begin
            cur = base_of(seed[s]);
            items[s*NB] = cur;
            for (int j = 1; j < NB; j++) begin
                cur = ca90_ring(cur, D, P);
                items[s*NB+j] = cur;
            end
        end
    endtask

    // Returns {index, distance} of the lowest-index nearest item.
    function automatic logic [31:0] model_search(input logic [D-1:0] q);
        int bi, bd, d;
        bi = 0;
        bd = D + 1;
        for (int i = 0; i < N; i++) begin
            d = $countones(items[i] ^ q);
            if (d < bd) begin
                bd = d;
                bi = i;
            end
        end
        return {bi[15:0], bd[15:0]};
    endfunction

    // Scoreboard: an accepted query becomes visible N edges later and stays until consumed.
    logic        m_pend;
    int          m_edges;
    logic [31:0] m_exp;
    logic [31:0] m_shown;

    always @(posedge clk) begin
        if (rst) begin
            m_pend  <= 1'b0;
            m_edges <= 0;
            m_shown <= '0;
        end else if (m_pend) begin
            if (m_edges >= N && result_ready) begin
                m_pend  <= 1'b0;
                m_shown <= m_exp;
            end else if (m_edges < N) begin
                m_edges <= m_edges + 1;
            end
        end else if (query_valid) begin
            m_pend  <= 1'b1;
            m_edges <= 0;
            m_exp   <= model_search(query_hv);
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("sb_busy", busy, m_pend);
            chk("sb_query_ready", query_ready, !m_pend);
            chk("sb_result_valid", result_valid, m_pend && m_edges >= N);
            if (m_pend && m_edges >= N) begin
                chk("sb_idx", result_idx, m_exp[31:16]);
                chk("sb_dist", result_dist, m_exp[15:0]);
            end else if (!m_pend) begin
                chk("sb_idx_held", result_idx, m_shown[31:16]);
                chk("sb_dist_held", result_dist, m_shown[15:0]);
            end
        end
    end

    // Called at a negedge; returns the cycle count just after the accepting edge.
    task automatic accept_query(input logic [D-1:0] q, input string tag, output int acc);
        int t;
        query_hv    = q;
        query_valid = 1'b1;
        t = 0;
        while (!query_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_accept"}, query_ready, 1);
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        query_valid = 1'b0;
    endtask

    // Returns at the negedge where result_valid is first seen; latency counts the accepting edge.
    task automatic wait_result(input int acc, input int ei, input int ed, input string tag);
        int t;
        t = 0;
        while (!result_valid && t < 1200) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_latency"}, cyc - acc + 1, N + 1);
        chk({tag, "_idx"}, result_idx, ei);
        chk({tag, "_dist"}, result_dist, ed);
    endtask

    initial begin
        int acc;
        logic [D-1:0] q;
        logic [31:0]  zres;

        rst          = 1'b1;
        query_valid  = 1'b0;
        query_hv     = '0;
        result_ready = 1'b1;
        for (int k = 0; k < NS; k++) seed[k] = 32'h1234_5678 + k;
        build_items();

        repeat (2) @(negedge clk);
        chk("reset_ready", query_ready, 1);
        chk("reset_valid", result_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_idx", result_idx, 0);
        chk("reset_dist", result_dist, 0);
        rst = 1'b0;

        // Hand-derived anchors for the golden table: low word is the seed, next word is
        // rotl1(seed) ^ rotr1(seed) = 0x2468ACF0 ^ 0x091A2B3C.
        chk("model_item0_lo", items[0][31:0], 32'h1234_5678);
        chk("model_item0_w1", items[0][63:32], 32'h2D72_87CC);
        chk("model_item128_lo", items[128][31:0], 32'h1234_5679);

        accept_query(items[0], "item0", acc);
        wait_result(acc, 0, 0, "item0");
        @(negedge clk);

        accept_query(items[777], "item777", acc);
        wait_result(acc, 777, 0, "item777");
        @(negedge clk);

        q = items[300];
        q[0] = ~q[0]; q[7] = ~q[7]; q[100] = ~q[100]; q[256] = ~q[256]; q[511] = ~q[511];
        accept_query(q, "item300f", acc);
        wait_result(acc, 300, 5, "item300f");
        @(negedge clk);

        q = '0;
        zres = model_search(q);
        accept_query(q, "zeros", acc);
        wait_result(acc, zres[31:16], zres[15:0], "zeros");
        @(negedge clk);

        // Consumer stalls; a new query waits in DONE until one cycle after the handshake.
        result_ready = 1'b0;
        accept_query(items[42], "hold", acc);
        wait_result(acc, 42, 0, "hold");
        query_hv    = items[10];
        query_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("hold_valid", result_valid, 1);
            chk("hold_idx", result_idx, 42);
            chk("hold_dist", result_dist, 0);
            chk("hold_no_accept", query_ready, 0);
        end
        result_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_valid", result_valid, 0);
        chk("hold_release_ready", query_ready, 1);
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        query_valid = 1'b0;
        chk("hold_next_busy", busy, 1);
        wait_result(acc, 10, 0, "hold_next");
        @(negedge clk);

        // Reset in the middle of a scan discards the search.
        accept_query(items[0], "abort", acc);
        repeat (499) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", query_ready, 1);
        chk("abort_valid", result_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_idx", result_idx, 0);
        chk("abort_dist", result_dist, 0);
        accept_query(items[1023], "item1023", acc);
        wait_result(acc, 1023, 0, "item1023");

        // Back-to-back: next query offered while the previous result is still showing.
        accept_query(items[5], "b2b_5", acc);
        wait_result(acc, 5, 0, "b2b_5");
        accept_query(items[900], "b2b_900", acc);
        wait_result(acc, 900, 0, "b2b_900");
        @(negedge clk);
        chk("b2b_drop", result_valid, 0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
